// File: rtl/wb_merge_if.sv
// wb_merge_if: bundle of the writeback-merge bus.
//   src_valid/src_ready/src_adr/src_data/src_pc : per-producer push channels
//                                                 (source i at slice i)
//   regw_enable/regw_adr/reg_write/regw_pc      : registered RF write port
//   q_adr/pend_hit                              : hazard-unit pending-write query
// slave  = the merge stage, master = producers + RF + hazard unit.
interface wb_merge_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int N_SRC  = 3
);
  logic [N_SRC-1:0]        src_valid;
  logic [N_SRC-1:0]        src_ready;
  logic [N_SRC*ADDR_W-1:0] src_adr;
  logic [N_SRC*DATA_W-1:0] src_data;
  logic [N_SRC*32-1:0]     src_pc;
  logic                    regw_enable;
  logic [ADDR_W-1:0]       regw_adr;
  logic [DATA_W-1:0]       reg_write;
  logic [31:0]             regw_pc;
  logic [ADDR_W-1:0]       q_adr;
  logic                    pend_hit;

  modport slave (
    input  src_valid, src_adr, src_data, src_pc, q_adr,
    output src_ready, regw_enable, regw_adr, reg_write, regw_pc, pend_hit
  );

  modport master (
    output src_valid, src_adr, src_data, src_pc, q_adr,
    input  src_ready, regw_enable, regw_adr, reg_write, regw_pc, pend_hit
  );
endinterface

// File: rtl/wb_merge.sv
// wb_merge: multi-source writeback stage.
//   clk, reset (sync, active low)
//   bus (wb_merge_if.slave): N_SRC push channels, one registered RF write
//   port, and a combinational pending-write query (q_adr -> pend_hit).
// Each source feeds a DEPTH-entry FIFO; a round-robin arbiter pops one
// entry per cycle into the output register. $0 entries are consumed but
// never strobe the register file.

// Per-source FIFO with an associative match of all live entries against
// the hazard query address.
module wb_merge_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_adr,
  input  logic [DATA_W-1:0] push_data,
  input  logic [31:0]       push_pc,
  input  logic [ADDR_W-1:0] q_adr,
  output logic              ready,
  output logic              nempty,
  output logic [ADDR_W-1:0] head_adr,
  output logic [DATA_W-1:0] head_data,
  output logic [31:0]       head_pc,
  output logic              hit
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] mem_adr  [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [31:0]       mem_pc   [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;

  // Ready looks only at the registered count: a full FIFO that pops this
  // cycle still refuses the push.
  assign ready     = reset && (count < CW'(DEPTH));
  assign nempty    = (count != '0);
  assign head_adr  = mem_adr[rd_ptr];
  assign head_data = mem_data[rd_ptr];
  assign head_pc   = mem_pc[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  // Storage needs no reset; push is already qualified by reset via ready.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_adr[wr_ptr]  <= push_adr;
      mem_data[wr_ptr] <= push_data;
      mem_pc[wr_ptr]   <= push_pc;
    end
  end

  // Only slots between rd_ptr and rd_ptr+count-1 hold live entries.
  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count) && (mem_adr[rd_ptr + PW'(k)] == q_adr)) hit = 1'b1;
    end
  end
endmodule

module wb_merge #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int N_SRC  = 3,
  parameter int DEPTH  = 2
) (
  input logic          clk,
  input logic          reset,
  wb_merge_if.slave    bus
);
  localparam int RW  = $clog2(N_SRC);
  localparam int RW1 = RW + 1;
  localparam logic [RW1-1:0] NS     = RW1'(N_SRC);
  localparam logic [RW-1:0]  LAST   = RW'(N_SRC - 1);

  logic [N_SRC-1:0]             src_rdy, push, pop, nempty, hit;
  logic [N_SRC-1:0][ADDR_W-1:0] head_adr;
  logic [N_SRC-1:0][DATA_W-1:0] head_data;
  logic [N_SRC-1:0][31:0]       head_pc;

  logic [RW-1:0]     rr, gnt;
  logic [RW1-1:0]    sidx;
  logic              gnt_vld;
  logic              en_q;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] data_q;
  logic [31:0]       pc_q;

  assign push = bus.src_valid & src_rdy;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    wb_merge_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push[i]),
      .pop      (pop[i]),
      .push_adr (bus.src_adr[i*ADDR_W +: ADDR_W]),
      .push_data(bus.src_data[i*DATA_W +: DATA_W]),
      .push_pc  (bus.src_pc[i*32 +: 32]),
      .q_adr    (bus.q_adr),
      .ready    (src_rdy[i]),
      .nempty   (nempty[i]),
      .head_adr (head_adr[i]),
      .head_data(head_data[i]),
      .head_pc  (head_pc[i]),
      .hit      (hit[i])
    );
  end

  // Scan rr, rr+1, ... (mod N_SRC) and take the first non-empty FIFO.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    sidx    = '0;
    for (int k = 0; k < N_SRC; k++) begin
      sidx = {1'b0, rr} + RW1'(k);
      if (sidx >= NS) sidx = sidx - NS;
      if (!gnt_vld && nempty[sidx[RW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt     = sidx[RW-1:0];
      end
    end
  end

  always_comb begin
    pop = '0;
    if (gnt_vld) pop[gnt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr     <= '0;
      en_q   <= 1'b0;
      adr_q  <= '0;
      data_q <= '0;
      pc_q   <= '0;
    end else begin
      // $0 results are drained but must never reach the register file.
      en_q <= gnt_vld && (head_adr[gnt] != '0);
      if (gnt_vld) begin
        rr     <= (gnt == LAST) ? '0 : gnt + 1'b1;
        adr_q  <= head_adr[gnt];
        data_q <= head_data[gnt];
        pc_q   <= head_pc[gnt];
      end
    end
  end

  assign bus.src_ready   = src_rdy;
  assign bus.regw_enable = en_q;
  assign bus.regw_adr    = adr_q;
  assign bus.reg_write   = data_q;
  assign bus.regw_pc     = pc_q;

  // The output stage counts as pending until the RF has committed it.
  assign bus.pend_hit = (bus.q_adr != '0) &&
                        ((|hit) || (en_q && (adr_q == bus.q_adr)));
endmodule

// File: tb/tb_wb_merge.sv
module tb_wb_merge;
  localparam int N = 3, DEPTH = 2, AW = 5, DW = 32;
  localparam int OW = 1 + AW + DW + 32 + 1 + N;

  typedef struct {
    logic [AW-1:0] adr;
    logic [DW-1:0] data;
    logic [31:0]   pc;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  wb_merge_if #(.DATA_W(DW), .ADDR_W(AW), .N_SRC(N)) bus();

  wb_merge #(.DATA_W(DW), .ADDR_W(AW), .N_SRC(N), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;

  // Reference model: queues per source, rr pointer, output register image.
  ent_t          mq[N][$];
  int            m_rr = 0;
  logic          m_en = 1'b0;
  logic [AW-1:0] m_adr = '0;
  logic [DW-1:0] m_data = '0;
  logic [31:0]   m_pc = '0;

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = reset && (mq[i].size() < DEPTH);
    return r;
  endfunction

  function automatic logic m_pend(logic [AW-1:0] q);
    if (q == 0) return 1'b0;
    if (m_en && m_adr == q) return 1'b1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < mq[i].size(); j++)
        if (mq[i][j].adr == q) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [OW-1:0] obs_v();
    return {bus.regw_enable, bus.regw_adr, bus.reg_write, bus.regw_pc, bus.pend_hit, bus.src_ready};
  endfunction

  function automatic logic [OW-1:0] exp_v();
    return {m_en, m_adr, m_data, m_pc, m_pend(bus.q_adr), m_ready()};
  endfunction

  task automatic drive(int i, logic v, logic [AW-1:0] a, logic [DW-1:0] d, logic [31:0] p);
    bus.src_valid[i]           = v;
    bus.src_adr[i*AW +: AW]    = a;
    bus.src_data[i*DW +: DW]   = d;
    bus.src_pc[i*32 +: 32]     = p;
  endtask

  task automatic idle();
    for (int i = 0; i < N; i++) drive(i, 1'b0, '0, '0, '0);
  endtask

  // Advance model by one edge using currently driven inputs, then let the
  // DUT take the same edge and settle.
  task automatic tick();
    logic [N-1:0] acc;
    ent_t e;
    bit gv;
    int g;
    if (!reset) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_rr = 0; m_en = 0; m_adr = '0; m_data = '0; m_pc = '0;
    end else begin
      acc = bus.src_valid & m_ready();
      gv = 0; g = 0;
      for (int k = 0; k < N; k++) begin
        int s = (m_rr + k) % N;
        if (!gv && mq[s].size() != 0) begin gv = 1; g = s; end
      end
      m_en = 1'b0;
      if (gv) begin
        e = mq[g].pop_front();
        m_en = (e.adr != 0);
        m_adr = e.adr; m_data = e.data; m_pc = e.pc;
        m_rr = (g + 1) % N;
      end
      for (int i = 0; i < N; i++) if (acc[i]) begin
        e.adr = bus.src_adr[i*AW +: AW];
        e.data = bus.src_data[i*DW +: DW];
        e.pc = bus.src_pc[i*32 +: 32];
        mq[i].push_back(e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle(); bus.q_adr = '0; reset = 1'b0;
    tick();
    nvec++; if (obs_v() !== exp_v()) begin nerr++; $display("FAIL reset_state: got %h want %h", obs_v(), exp_v()); end
    nvec++; if (bus.src_ready !== '0 || bus.regw_enable !== 1'b0 || bus.pend_hit !== 1'b0)
      begin nerr++; $display("FAIL reset_outs: rdy=%b en=%b pend=%b want 0", bus.src_ready, bus.regw_enable, bus.pend_hit); end
    reset = 1'b1;
    tick();
    nvec++; if (bus.src_ready !== 3'b111) begin nerr++; $display("FAIL reset_release_ready: got %b want 111", bus.src_ready); end
  endtask

  task automatic test_single();
    bus.q_adr = 5'd5;
    drive(0, 1'b1, 5'd5, 32'h1234, 32'h3000);
    tick(); idle();
    nvec++; if (obs_v() !== exp_v()) begin nerr++; $display("FAIL single_e1: got %h want %h", obs_v(), exp_v()); end
    nvec++; if (bus.pend_hit !== 1'b1 || bus.regw_enable !== 1'b0)
      begin nerr++; $display("FAIL single_e1_pend: pend=%b en=%b want pend=1 en=0", bus.pend_hit, bus.regw_enable); end
    tick();
    nvec++; if (obs_v() !== exp_v()) begin nerr++; $display("FAIL single_e2: got %h want %h", obs_v(), exp_v()); end
    nvec++; if ({bus.regw_enable, bus.regw_adr, bus.reg_write, bus.regw_pc, bus.pend_hit} !== {1'b1, 5'd5, 32'h1234, 32'h3000, 1'b1})
      begin nerr++; $display("FAIL single_write: en=%b adr=%0d data=%h pc=%h pend=%b", bus.regw_enable, bus.regw_adr, bus.reg_write, bus.regw_pc, bus.pend_hit); end
    tick();
    nvec++; if (bus.regw_enable !== 1'b0 || bus.pend_hit !== 1'b0)
      begin nerr++; $display("FAIL single_e3: en=%b pend=%b want 0 0", bus.regw_enable, bus.pend_hit); end
  endtask

  task automatic test_contention();
    logic [AW-1:0] seq [3];
    reset = 1'b0; tick(); reset = 1'b1;
    for (int i = 0; i < N; i++) drive(i, 1'b1, 5'(i + 1), $urandom(), 32'h100 + i);
    bus.q_adr = 5'd2;
    tick(); idle();
    for (int c = 0; c < 3; c++) begin
      tick();
      nvec++; if (obs_v() !== exp_v()) begin nerr++; $display("FAIL contention_c%0d: got %h want %h", c, obs_v(), exp_v()); end
      seq[c] = bus.regw_enable ? bus.regw_adr : 5'd0;
    end
    nvec++; if (seq[0] !== 5'd1 || seq[1] !== 5'd2 || seq[2] !== 5'd3)
      begin nerr++; $display("FAIL contention_order: got %0d,%0d,%0d want 1,2,3", seq[0], seq[1], seq[2]); end
    // rr must be back at 0: source 0 beats source 2.
    drive(2, 1'b1, 5'd9, 32'hA9, 32'h209);
    drive(0, 1'b1, 5'd8, 32'hA8, 32'h208);
    tick(); idle(); tick();
    nvec++; if (bus.regw_enable !== 1'b1 || bus.regw_adr !== 5'd8)
      begin nerr++; $display("FAIL contention_rr_end: en=%b adr=%0d want 1 8", bus.regw_enable, bus.regw_adr); end
    tick();
    nvec++; if (obs_v() !== exp_v()) begin nerr++; $display("FAIL contention_tail: got %h want %h", obs_v(), exp_v()); end
    repeat (2) tick();
  endtask

  task automatic test_backpressure();
    int n0 = 0, n1 = 0;
    logic [N-1:0] acc;
    logic [AW-1:0] got1[$];
    bus.q_adr = 5'd6;
    for (int c = 0; c < 20; c++) begin
      idle();
      if (n1 < 3) begin
        drive(1, 1'b1, 5'(4 + n1), 32'hB000 + n1, 32'h1000_0000 + n1);
        drive(0, 1'b1, 5'(10 + n0 % 16), $urandom(), 32'h0000_0000 + n0);
      end
      acc = bus.src_valid & m_ready();
      tick();
      if (acc[0]) n0++;
      if (acc[1]) n1++;
      nvec++; if (obs_v() !== exp_v()) begin nerr++; $display("FAIL backpressure_c%0d: got %h want %h", c, obs_v(), exp_v()); end
      if (bus.regw_enable && bus.regw_pc[31:28] == 4'd1) got1.push_back(bus.regw_adr);
      if (acc[1] && n1 == 2) begin
        nvec++; if (bus.src_ready[1] !== 1'b0) begin nerr++; $display("FAIL backpressure_full: src_ready[1]=%b want 0", bus.src_ready[1]); end
      end
    end
    idle();
    nvec++; if (got1.size() != 3 || got1[0] !== 5'd4 || got1[1] !== 5'd5 || got1[2] !== 5'd6)
      begin nerr++; $display("FAIL backpressure_order: got %0d writes (%p) want 4,5,6", got1.size(), got1); end
  endtask

  task automatic test_zero();
    bus.q_adr = 5'd0;
    drive(2, 1'b1, 5'd0, 32'hFFFF, 32'h2000);
    tick(); idle();
    for (int c = 0; c < 3; c++) begin
      nvec++; if (obs_v() !== exp_v()) begin nerr++; $display("FAIL zero_c%0d: got %h want %h", c, obs_v(), exp_v()); end
      nvec++; if (bus.regw_enable !== 1'b0 || bus.pend_hit !== 1'b0)
        begin nerr++; $display("FAIL zero_drop_c%0d: en=%b pend=%b want 0 0", c, bus.regw_enable, bus.pend_hit); end
      tick();
    end
    nvec++; if (bus.src_ready[2] !== 1'b1) begin nerr++; $display("FAIL zero_empty: src_ready[2]=%b want 1", bus.src_ready[2]); end
  endtask

  task automatic test_reset_mid();
    bus.q_adr = 5'd21;
    for (int i = 0; i < N; i++) drive(i, 1'b1, 5'(20 + i), $urandom(), 32'h4000 + i);
    tick();
    idle();
    drive(0, 1'b1, 5'd23, $urandom(), 32'h4003);
    drive(1, 1'b1, 5'd24, $urandom(), 32'h4004);
    tick();
    // Push offered during the reset edge must be discarded.
    idle();
    drive(0, 1'b1, 5'd25, 32'h55, 32'h4005);
    reset = 1'b0;
    tick();
    idle();
    nvec++; if (obs_v() !== exp_v()) begin nerr++; $display("FAIL reset_mid: got %h want %h", obs_v(), exp_v()); end
    nvec++; if ({bus.src_ready, bus.regw_enable, bus.regw_adr, bus.reg_write, bus.regw_pc, bus.pend_hit} !== '0)
      begin nerr++; $display("FAIL reset_mid_zero: rdy=%b en=%b adr=%0d data=%h pc=%h pend=%b", bus.src_ready, bus.regw_enable, bus.regw_adr, bus.reg_write, bus.regw_pc, bus.pend_hit); end
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      nvec++; if (bus.regw_enable !== 1'b0 || obs_v() !== exp_v())
        begin nerr++; $display("FAIL reset_mid_after_c%0d: got %h want %h", c, obs_v(), exp_v()); end
    end
  endtask

  task automatic test_fairness();
    ent_t sq[N][$];
    ent_t cur[N];
    ent_t e;
    int seq[N];
    int cnt[N];
    int total = 0;
    logic [N-1:0] acc;
    int s;
    reset = 1'b0; idle(); tick(); reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      seq[i] = 0; cnt[i] = 0;
      cur[i].adr = 5'($urandom_range(31, 1)); cur[i].data = $urandom(); cur[i].pc = {4'(i), 28'(0)};
    end
    for (int c = 0; c < 100 && total < 30; c++) begin
      for (int i = 0; i < N; i++) drive(i, 1'b1, cur[i].adr, cur[i].data, cur[i].pc);
      bus.q_adr = 5'($urandom_range(31, 0));
      acc = bus.src_valid & m_ready();
      for (int i = 0; i < N; i++) if (acc[i]) sq[i].push_back(cur[i]);
      tick();
      for (int i = 0; i < N; i++) if (acc[i]) begin
        seq[i]++;
        cur[i].adr = 5'($urandom_range(31, 1)); cur[i].data = $urandom(); cur[i].pc = {4'(i), 28'(seq[i])};
      end
      nvec++; if (obs_v() !== exp_v()) begin nerr++; $display("FAIL fairness_c%0d: got %h want %h", c, obs_v(), exp_v()); end
      if (bus.regw_enable === 1'b1) begin
        s = int'(bus.regw_pc[31:28]);
        nvec++;
        if (s >= N || sq[s].size() == 0) begin
          nerr++; $display("FAIL fairness_src: write pc=%h from no pending source", bus.regw_pc);
        end else begin
          e = sq[s].pop_front();
          if ({bus.regw_adr, bus.reg_write, bus.regw_pc} !== {e.adr, e.data, e.pc}) begin
            nerr++; $display("FAIL fairness_order_src%0d: got adr=%0d data=%h pc=%h want adr=%0d data=%h pc=%h", s, bus.regw_adr, bus.reg_write, bus.regw_pc, e.adr, e.data, e.pc);
          end
          cnt[s]++; total++;
        end
      end
    end
    idle();
    nvec++; if (total != 30) begin nerr++; $display("FAIL fairness_timeout: got %0d writes want 30", total); end
    for (int i = 0; i < N; i++) begin
      nvec++; if (cnt[i] != 10) begin nerr++; $display("FAIL fairness_count_src%0d: got %0d want 10", i, cnt[i]); end
    end
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_zero();
    test_reset_mid();
    test_fairness();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/wb_merge.md
# wb_merge

Parametrised multi-source writeback stage for the pipelined MIPS core. It accepts completed results from N_SRC producers (ALU path, memory path, multiply/divide unit, …) through per-source valid/ready FIFOs. Each cycle it selects one result by round-robin and drives a single registered register-file write port. It also answers a pending-write query so the hazard unit can stall readers of registers with queued writes.

## Interface
- DATA_W, 32, result and write-data width
- ADDR_W, 5, register address width
- N_SRC, 3, number of producer channels (2..8)
- DEPTH, 2, entries per source FIFO (power of two, 2..8)
- clk  in  1  rising-edge clock, single clock domain
- reset  in  1  synchronous, active-low reset; sampled on rising edge of clk
- src_valid  in  N_SRC  bit i: producer i offers a result
- src_ready  out  N_SRC  bit i: FIFO i can accept this cycle
- src_adr  in  N_SRC*ADDR_W  destination register of source i, slice [i*ADDR_W +: ADDR_W]
- src_data  in  N_SRC*DATA_W  result of source i, slice [i*DATA_W +: DATA_W]
- src_pc  in  N_SRC*32  instruction PC of source i, for trace
- regw_enable  out  1  register-file write strobe
- regw_adr  out  ADDR_W  write address
- reg_write  out  DATA_W  write data
- regw_pc  out  32  PC of the instruction being written
- q_adr  in  ADDR_W  hazard query address
- pend_hit  out  1  a write to q_adr is queued or on the output port

## Operation
- Push: on an edge with reset high, src_valid[i] and src_ready[i] high, entry {adr, data, pc} is written to FIFO i.
- src_ready[i] = (count_i < DEPTH) and reset high. It depends only on registered count, not on same-cycle pop.
- Simultaneous push and pop on one FIFO is legal; count is unchanged. A full FIFO that pops in a cycle still shows ready low in that cycle.
- Per-source order is strictly FIFO. There is no ordering guarantee across sources; producers own cross-source ordering.
- Arbitration: pointer rr (0..N_SRC-1) resets to 0. Grant goes to the first non-empty FIFO scanning rr, rr+1, … mod N_SRC.
  - On a grant to g, one entry pops from FIFO g and rr becomes (g+1) mod N_SRC.
  - With no FIFO non-empty, rr holds.
- Output register loads on every edge:
  - regw_enable = grant_valid and (popped adr != 0).
  - regw_adr, reg_write, regw_pc load the popped entry on a grant and hold otherwise.
- $0 writes are consumed from the FIFO but never assert regw_enable.
- pend_hit is combinational. It is 1 iff q_adr != 0 and either:
  - any valid entry in any FIFO has adr == q_adr, or
  - regw_enable is high with regw_adr == q_adr.
- Reset (low at an edge, including mid-operation):
  - all FIFOs emptied, rr = 0;
  - regw_enable = 0, regw_adr = 0, reg_write = 0, regw_pc = 0;
  - incoming pushes in that cycle are discarded.

## Timing
- Latency is 2 edges. A push at edge k makes the entry eligible in the cycle after k. If granted, it pops at edge k+1, and regw_enable is high from k+1 until k+2.
- Throughput: one write per cycle total across all sources.
- Under full contention each source is granted at least once every N_SRC cycles.
- pend_hit covers an entry from the edge it is pushed until the edge after its regw_enable cycle, which is when the register file has committed the write.
- During the cycle reset is held low, src_ready = 0. pend_hit = 0, because all state is cleared from the first reset edge onward.

## Test plan
- Single push: src 0 pushes adr=5, data=0x1234, pc=0x3000 at edge 1. Required: regw_enable=1, regw_adr=5, reg_write=0x1234, regw_pc=0x3000 in the cycle after edge 2, and 0 otherwise. pend_hit with q_adr=5 is 1 from after edge 1 through after edge 2.
- Contention: all 3 sources push one entry at the same edge with adr 1,2,3 from rr=0. Required: writes appear in order 1,2,3 on three consecutive cycles, and rr ends at 0.
- Backpressure: with DEPTH=2, src 1 pushes adr 4,5,6 while src 0 holds priority with continuous traffic. Required: src_ready[1]=0 after the 2nd push, the 3rd push is held, and src 1 writes 4,5,6 in order with none lost.
- $0 drop: push adr=0, data=0xFFFF. Required: regw_enable stays 0, the FIFO empties, and pend_hit with q_adr=0 is 0.
- Reset mid-operation: with FIFOs holding 4 entries, drive reset low for one edge. Required: all outputs 0, src_ready 0 during reset, and no queued entry is ever written afterwards.
- Fairness sweep: saturate all sources for 30 cycles with random adr/data. Required: each source is granted exactly 10 times and the per-source output order matches the push order.
